// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-access stage: FSM encoding and default sizing.
package mem_ctrl_pkg;

    localparam int unsigned STATE_W         = 2;
    localparam int unsigned DEFAULT_DATA_W  = 16;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// WAIT-phase watchdog: clear/enable counter whose tc flags count == TIMEOUT.
module mem_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: ALU pass-through, multi-cycle load/store handshake, one registered result per op.
// Optional MEM_ALIGN_CHECK_EN rejects loads/stores to odd addresses as illegal ops.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = DEFAULT_DATA_W,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_aluo,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_regwrite,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_stall,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
);

    state_t            state;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic              regwrite_q;
    logic              accept;
    logic              is_mem;
    logic              bad_op;
    logic              tc;

    assign accept = ex_valid & ex_ready;
    assign is_mem = ex_memread | ex_memwrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign bad_op = (ex_memread & ex_memwrite) | (is_mem & ex_aluo[0]);
`else
    assign bad_op = ex_memread & ex_memwrite;
`endif

    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == ISSUE),
        .enable ((state == WAIT) & ~mem_done & ~tc),
        .tc     (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            regwrite_q <= 1'b0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_data    <= '0;
            err        <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bad_op) begin
                            err      <= 1'b1;
                            wb_valid <= 1'b1;
                            wb_we    <= 1'b0;
                            wb_data  <= '0;
                        end else if (is_mem) begin
                            addr_q     <= ex_aluo;
                            wdata_q    <= ex_wdata;
                            wr_q       <= ex_memwrite;
                            regwrite_q <= ex_regwrite;
                            state      <= ISSUE;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_we    <= ex_regwrite;
                            wb_data  <= ex_aluo;
                        end
                    end
                end
                ISSUE: begin
                    if (!mem_stall) state <= WAIT;
                end
                WAIT: begin
                    // A done on the terminal-count cycle still wins over the timeout.
                    if (mem_done) begin
                        wb_valid <= 1'b1;
                        wb_we    <= wr_q ? 1'b0 : regwrite_q;
                        wb_data  <= wr_q ? addr_q : mem_rdata;
                        state    <= IDLE;
                    end else if (tc) begin
                        err      <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_we    <= 1'b0;
                        wb_data  <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request lines decode straight from state so reset drops them without waiting for a clock.
    assign ex_ready  = (state == IDLE);
    assign mem_en    = (state == ISSUE);
    assign mem_wr    = mem_en & wr_q;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_mem_access_ctrl;

    typedef struct packed {
        logic        we;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [15:0] ex_aluo;
    logic [15:0] ex_wdata;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_regwrite;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_stall;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [15:0] wb_data;
    logic        err;

    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];

    mem_access_ctrl #(.DATA_W(16), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_aluo    (ex_aluo),
        .ex_wdata   (ex_wdata),
        .ex_memread (ex_memread),
        .ex_memwrite(ex_memwrite),
        .ex_regwrite(ex_regwrite),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_stall  (mem_stall),
        .mem_done   (mem_done),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_data    (wb_data),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [15:0] aluo, input logic [15:0] wdata,
                            input logic rd, input logic wr, input logic rw);
        ex_valid    = 1'b1;
        ex_aluo     = aluo;
        ex_wdata    = wdata;
        ex_memread  = rd;
        ex_memwrite = wr;
        ex_regwrite = rw;
    endtask

    task automatic idle_in();
        ex_valid    = 1'b0;
        ex_aluo     = '0;
        ex_wdata    = '0;
        ex_memread  = 1'b0;
        ex_memwrite = 1'b0;
        ex_regwrite = 1'b0;
    endtask

    task automatic push(input logic we, input logic [15:0] data, input logic e);
        exp_t x;
        x.we   = we;
        x.data = data;
        x.err  = e;
        sb_q.push_back(x);
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            check("wb_has_expect", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("wb_we", wb_we, e.we);
                check("wb_data", wb_data, e.data);
                check("wb_err", err, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        mem_stall = 1'b0;
        mem_done  = 1'b0;
        mem_rdata = '0;
        idle_in();
        repeat (3) tick();
        check("rst_ex_ready", ex_ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_err", err, 0);
        check("rst_wb_data", wb_data, 0);
        rst_n = 1'b1;
        tick();

        // Back-to-back ALU ops, one result per cycle.
        for (int i = 0; i < 3; i++) begin
            logic [15:0] v;
            v = 16'h0011 * 16'(i + 1);
            drive_op(v, 16'h0, 1'b0, 1'b0, 1'b1);
            push(1'b1, v, 1'b0);
            check("alu_ready", ex_ready, 1);
            tick();
        end
        idle_in();
        check("alu_ready_after", ex_ready, 1);

        // Load with two stall cycles; a stray done during ISSUE is ignored.
        drive_op(16'h0040, 16'h0, 1'b1, 1'b0, 1'b1);
        mem_stall = 1'b1;
        push(1'b1, 16'hBEEF, 1'b0);
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            check("ld_issue_en", mem_en, 1);
            check("ld_issue_addr", mem_addr, 16'h0040);
            check("ld_issue_wr", mem_wr, 0);
            check("ld_issue_ready", ex_ready, 0);
            mem_stall = (i < 2);
            mem_done  = (i == 0);
            tick();
        end
        mem_done = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("ld_wait_en", mem_en, 0);
            check("ld_wait_addr", mem_addr, 0);
            check("ld_wait_ready", ex_ready, 0);
            mem_done  = (j == 2);
            mem_rdata = (j == 2) ? 16'hBEEF : 16'h1111;
            tick();
        end
        mem_done = 1'b0;
        check("ld_done_ready", ex_ready, 1);

        // Store, done on the first WAIT cycle.
        drive_op(16'h0100, 16'h1234, 1'b0, 1'b1, 1'b0);
        push(1'b0, 16'h0100, 1'b0);
        tick();
        idle_in();
        check("st_issue_en", mem_en, 1);
        check("st_issue_wr", mem_wr, 1);
        check("st_issue_wdata", mem_wdata, 16'h1234);
        check("st_issue_addr", mem_addr, 16'h0100);
        tick();
        check("st_wait_en", mem_en, 0);
        check("st_wait_wr", mem_wr, 0);
        check("st_wait_wdata", mem_wdata, 0);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        check("st_done_ready", ex_ready, 1);

        // Odd-address load.
        drive_op(16'h0041, 16'h0, 1'b1, 1'b0, 1'b1);
`ifdef MEM_ALIGN_CHECK_EN
        push(1'b0, 16'h0000, 1'b1);
        tick();
        idle_in();
        check("odd_no_en", mem_en, 0);
        check("odd_ready", ex_ready, 1);
`else
        push(1'b1, 16'hCAFE, 1'b0);
        tick();
        idle_in();
        check("odd_en", mem_en, 1);
        check("odd_addr", mem_addr, 16'h0041);
        tick();
        mem_done  = 1'b1;
        mem_rdata = 16'hCAFE;
        tick();
        mem_done  = 1'b0;
`endif

        // Illegal op: both memread and memwrite.
        drive_op(16'h0055, 16'h0066, 1'b1, 1'b1, 1'b1);
        push(1'b0, 16'h0000, 1'b1);
        tick();
        idle_in();
        check("ill_no_en", mem_en, 0);
        check("ill_ready", ex_ready, 1);
        tick();
        check("ill_err", err, 1);
        check("ill_no_en2", mem_en, 0);

        // Clear err before the timeout test.
        rst_n = 1'b0;
        #1;
        check("rst2_err", err, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Load that never completes: watchdog abandons it.
        drive_op(16'h0200, 16'h0, 1'b1, 1'b0, 1'b1);
        push(1'b0, 16'h0000, 1'b1);
        tick();
        idle_in();
        check("to_issue_en", mem_en, 1);
        tick();
        n = 0;
        while (!ex_ready && n < 30) begin
            tick();
            n++;
        end
        check("to_ready", ex_ready, 1);
        check("to_min_wait", n >= 4, 1);
        check("to_err", err, 1);
        drive_op(16'h0077, 16'h0, 1'b0, 1'b0, 1'b1);
        push(1'b1, 16'h0077, 1'b1);
        tick();
        idle_in();
        tick();
        check("to_err_sticky", err, 1);

        // Reset while the request is being presented.
        drive_op(16'h0300, 16'h0, 1'b1, 1'b0, 1'b1);
        mem_stall = 1'b1;
        tick();
        idle_in();
        check("rsti_en_before", mem_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rsti_en_async", mem_en, 0);
        check("rsti_ready", ex_ready, 1);
        tick();
        rst_n     = 1'b1;
        mem_stall = 1'b0;
        tick();

        // Reset mid-WAIT; a late done must produce no result.
        drive_op(16'h0400, 16'h0, 1'b1, 1'b0, 1'b1);
        tick();
        idle_in();
        tick();
        check("rstw_busy", ex_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rstw_ready", ex_ready, 1);
        check("rstw_en", mem_en, 0);
        tick();
        rst_n     = 1'b1;
        mem_done  = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_done = 1'b0;
        tick();
        check("rstw_idle", ex_ready, 1);
        check("rstw_en_idle", mem_en, 0);

        repeat (3) tick();
        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
